// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives im_addr, buffers fetched words
// in a small FIFO and presents {pc, inst, flags} downstream via valid/ready.
// A misaligned or out-of-window PC produces one flagged entry and halts
// fetching until the next redirect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | issue one fetch per cycle whenever the FIFO can take it
// ST_HALT  | flagged entry issued; pc held, no fetch until redirect
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          IM_ADDR_BITS = 14,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] im_addr,
  input  logic [31:0] im_dout,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_misalign,
  output logic        out_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  state_t            state;
  logic [63:0]       pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [63:0]       fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_inst [FIFO_DEPTH];
  logic              fifo_mis  [FIFO_DEPTH];
  logic              fifo_flt  [FIFO_DEPTH];

  logic              pop;
  logic              push;
  logic              full;
  logic              fetch_misalign;
  logic              fetch_fault;
  logic              fetch_flagged;
  logic [31:0]       fetch_inst;
  logic [CNT_W-1:0]  count_after_pop;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [63:0]       head_pc_next;
  logic [31:0]       head_inst_next;
  logic              head_mis_next;
  logic              head_flt_next;

  // The fetch address is the PC register itself, no input feeds it.
  assign im_addr = pc;

  // Handshake, push enable and flag classification of the word being fetched.
  always_comb begin
    pop            = out_valid && out_ready;
    full           = (count == CNT_W'(FIFO_DEPTH));
    push           = (state == ST_FETCH) && !redirect_valid && (!full || pop);
    fetch_misalign = (pc[1:0] != 2'b00);
    fetch_fault    = !fetch_misalign && (pc[63:IM_ADDR_BITS] != '0);
    fetch_flagged  = fetch_misalign || fetch_fault;
    fetch_inst     = fetch_flagged ? 32'h0 : im_dout;
  end

  // Next occupancy, pointers, and the entry that will sit at the head after the edge.
  always_comb begin
    count_after_pop = pop ? (count - CNT_W'(1)) : count;
    count_next      = push ? (count_after_pop + CNT_W'(1)) : count_after_pop;
    rd_ptr_next     = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    wr_ptr_next     = push ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    if (redirect_valid) begin
      count_next  = '0;
      rd_ptr_next = wr_ptr;
      wr_ptr_next = wr_ptr;
    end
    // When the FIFO drains to nothing but a push arrives, the new word
    // bypasses the storage array straight into the output registers.
    if (count_after_pop == '0) begin
      head_pc_next   = pc;
      head_inst_next = fetch_inst;
      head_mis_next  = fetch_misalign;
      head_flt_next  = fetch_fault;
    end else begin
      head_pc_next   = fifo_pc[rd_ptr_next];
      head_inst_next = fifo_inst[rd_ptr_next];
      head_mis_next  = fifo_mis[rd_ptr_next];
      head_flt_next  = fifo_flt[rd_ptr_next];
    end
  end

  // FIFO storage; contents only matter while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_inst[wr_ptr] <= fetch_inst;
      fifo_mis[wr_ptr]  <= fetch_misalign;
      fifo_flt[wr_ptr]  <= fetch_fault;
    end
  end

  // FIFO bookkeeping and the registered head view presented downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_pc       <= 64'h0;
      out_inst     <= 32'h0;
      out_misalign <= 1'b0;
      out_fault    <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      // Fields hold their last values whenever nothing is left to show.
      if (count_next != '0) begin
        out_pc       <= head_pc_next;
        out_inst     <= head_inst_next;
        out_misalign <= head_mis_next;
        out_fault    <= head_flt_next;
      end
    end
  end

  // PC / fetch state machine; redirect wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= ST_FETCH;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      state <= ST_FETCH;
    end else if (push) begin
      if (fetch_flagged) begin
        state <= ST_HALT;
      end else begin
        pc <= pc + 64'd4;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a behavioural queue model predicts every cycle's
// head entry and PC; a stimulus table drives most of the run, with
// hand-written reset and random-handshake sequences around it.
module tb_if_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [63:0] im_addr;
  logic [31:0] im_dout;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;
  logic        out_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
    logic        flt;
  } entry_t;

  typedef struct {
    bit          rv;
    logic [63:0] rpc;
    bit          rdy;
    int          cycles;
    logic [63:0] exp_im;
  } step_t;

  entry_t      m_q[$];
  entry_t      m_last;
  logic [63:0] m_pc;
  bit          m_halt;
  step_t       steps[$];

  if_fetch_stage #(
    .RESET_PC    (64'h0),
    .IM_ADDR_BITS(14),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .im_addr       (im_addr),
    .im_dout       (im_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_misalign  (out_misalign),
    .out_fault     (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  always_comb im_dout = mem_word(im_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("im_addr", im_addr, m_pc);
    chk("out_valid", {63'h0, out_valid}, {63'h0, (m_q.size() != 0)});
    chk("out_pc", out_pc, m_last.pc);
    chk("out_inst", {32'h0, out_inst}, {32'h0, m_last.inst});
    chk("out_misalign", {63'h0, out_misalign}, {63'h0, m_last.mis});
    chk("out_fault", {63'h0, out_fault}, {63'h0, m_last.flt});
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = 64'h0;
    m_halt = 1'b0;
    m_last = '{64'h0, 32'h0, 1'b0, 1'b0};
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic cycle(input bit rv, input logic [63:0] rpc, input bit rdy);
    int     sz;
    bit     pop;
    bit     push;
    entry_t e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    sz  = m_q.size();
    pop = (sz != 0) && rdy;
    if (rv) begin
      m_q.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
    end else begin
      push = !m_halt && ((sz < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        e.pc   = m_pc;
        e.mis  = (m_pc[1:0] != 2'b00);
        e.flt  = !e.mis && ((m_pc >> 14) != 64'h0);
        e.inst = (e.mis || e.flt) ? 32'h0 : mem_word(m_pc);
        m_q.push_back(e);
        if (e.mis || e.flt) m_halt = 1'b1;
        else                m_pc   = m_pc + 64'd4;
      end
    end
    if (m_q.size() != 0) m_last = m_q[0];
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
    model_reset();

    // {redirect_valid, redirect_pc, out_ready, cycles, im_addr expected after the step}
    steps.push_back('{1'b0, 64'h0,    1'b1, 4,  64'h10});
    steps.push_back('{1'b0, 64'h0,    1'b0, 5,  64'h14});
    steps.push_back('{1'b0, 64'h0,    1'b1, 3,  64'h20});
    steps.push_back('{1'b0, 64'h0,    1'b0, 2,  64'h20});
    steps.push_back('{1'b1, 64'h40,   1'b1, 1,  64'h40});
    steps.push_back('{1'b0, 64'h0,    1'b1, 3,  64'h4C});
    steps.push_back('{1'b1, 64'h42,   1'b1, 1,  64'h42});
    steps.push_back('{1'b0, 64'h0,    1'b1, 12, 64'h42});
    steps.push_back('{1'b1, 64'h10,   1'b1, 1,  64'h10});
    steps.push_back('{1'b0, 64'h0,    1'b1, 2,  64'h18});
    steps.push_back('{1'b1, 64'h4000, 1'b1, 1,  64'h4000});
    steps.push_back('{1'b0, 64'h0,    1'b0, 4,  64'h4000});
    steps.push_back('{1'b0, 64'h0,    1'b1, 2,  64'h4000});
    steps.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFC});
    steps.push_back('{1'b0, 64'h0,    1'b1, 5,  64'hFFFF_FFFF_FFFF_FFFC});
    steps.push_back('{1'b1, 64'h3FF8, 1'b1, 1,  64'h3FF8});
    steps.push_back('{1'b0, 64'h0,    1'b1, 4,  64'h4000});
    steps.push_back('{1'b1, 64'h100,  1'b0, 1,  64'h100});
    steps.push_back('{1'b0, 64'h0,    1'b0, 3,  64'h108});
    steps.push_back('{1'b1, 64'h200,  1'b1, 1,  64'h200});
    steps.push_back('{1'b0, 64'h0,    1'b1, 2,  64'h208});

    // Reset values, asynchronously applied.
    #1;
    compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    foreach (steps[i]) begin
      for (int c = 0; c < steps[i].cycles; c++) begin
        cycle(steps[i].rv, steps[i].rpc, steps[i].rdy);
      end
      chk($sformatf("step%0d_im_addr", i), im_addr, steps[i].exp_im);
    end

    // Fill the FIFO from a fresh base, then drop reset between edges.
    cycle(1'b1, 64'h80, 1'b0);
    repeat (3) cycle(1'b0, 64'h0, 1'b0);
    chk("full_before_reset", {63'h0, out_valid}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("async_rst_im_addr", im_addr, 64'h0);
    chk("async_rst_out_pc", out_pc, 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    repeat (5) cycle(1'b0, 64'h0, 1'b1);

    // Random handshake with occasional redirects, some misaligned or out of window.
    for (int r = 0; r < 120; r++) begin
      bit          rv;
      logic [63:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {50'h0, 14'($urandom_range(0, 16383))};
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc[20] = 1'b1;
      cycle(rv, rpc, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
